// File: rtl/pipe_stage_skid.sv
// One-entry skid-buffered pipeline stage with valid/ready handshake.
// A separate hold/flush control bus stalls the stage or replaces it with a bubble.
module pipe_stage_skid #(
  parameter int unsigned             WIDTH     = 32,
  parameter logic [WIDTH-1:0]        RESET_VAL = '0,
  parameter logic [WIDTH-1:0]        NOP_VAL   = '0,
  parameter int unsigned             HOLD_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOLD_W-1:0] hold_flag,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy
);

  localparam logic [HOLD_W-1:0] CODE_FLUSH = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] CODE_HOLD  = HOLD_W'(2);

  logic             flush;
  logic             hold;
  logic             acc;
  logic             emit;

  logic [WIDTH-1:0] main_d_reg, main_d_next;
  logic             main_v_reg, main_v_next;
  logic [WIDTH-1:0] skid_d_reg, skid_d_next;
  logic             skid_v_reg, skid_v_next;
  logic [1:0]       occ_reg, occ_next;

  assign flush     = (hold_flag == CODE_FLUSH);
  assign hold      = (hold_flag == CODE_HOLD);
  assign in_ready  = !skid_v_reg && !flush && !hold;
  assign out_valid = main_v_reg && !flush && !hold;
  assign acc       = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  assign out_data  = main_d_reg;
  assign occupancy = occ_reg;

  always_comb begin
    main_d_next = main_d_reg;
    main_v_next = main_v_reg;
    skid_d_next = skid_d_reg;
    skid_v_next = skid_v_reg;

    if (flush) begin
      // Bubble insertion: skid payload is left in place but marked invalid.
      main_v_next = 1'b0;
      skid_v_next = 1'b0;
      main_d_next = NOP_VAL;
    end else if (!hold) begin
      if (!main_v_reg) begin
        if (acc) begin
          main_d_next = in_data;
          main_v_next = 1'b1;
        end
      end else if (!skid_v_reg) begin
        if (emit && acc) begin
          main_d_next = in_data;
        end else if (emit) begin
          main_v_next = 1'b0;
        end else if (acc) begin
          skid_d_next = in_data;
          skid_v_next = 1'b1;
        end
      end else if (emit) begin
        // Skid full means in_ready is low, so only a refill from skid happens.
        main_d_next = skid_d_reg;
        skid_v_next = 1'b0;
      end
    end

    occ_next = {1'b0, main_v_next} + {1'b0, skid_v_next};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_d_reg <= RESET_VAL;
      main_v_reg <= 1'b0;
      skid_d_reg <= RESET_VAL;
      skid_v_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      main_d_reg <= main_d_next;
      main_v_reg <= main_v_next;
      skid_d_reg <= skid_d_next;
      skid_v_reg <= skid_v_next;
      occ_reg    <= occ_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a two-deep queue predicts handshakes,
// payload order and occupancy; scenario tasks add targeted checks.
module tb_pipe_stage_skid;

  localparam int unsigned      WIDTH     = 16;
  localparam logic [WIDTH-1:0] RESET_VAL = 16'hDEAD;
  localparam logic [WIDTH-1:0] NOP_VAL   = 16'h0013;
  localparam int unsigned      HOLD_W    = 3;

  logic              clk;
  logic              rst;
  logic [HOLD_W-1:0] hold_flag;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        occupancy;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_val;

  pipe_stage_skid #(
    .WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .NOP_VAL(NOP_VAL), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst(rst), .hold_flag(hold_flag),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of scoreboard: predict and compare mid-cycle, update on the edge.
  task automatic step();
    bit f, h, exp_ir, exp_ov, acc, emit;
    logic [WIDTH-1:0] exp_od;
    @(negedge clk);
    f      = (hold_flag == 3'b001);
    h      = (hold_flag == 3'b010);
    exp_ir = (sb.size() < 2) && !f && !h;
    exp_ov = (sb.size() > 0) && !f && !h;
    exp_od = (sb.size() > 0) ? sb[0] : last_val;
    checks++;
    if (in_ready !== exp_ir) begin
      errors++;
      $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_ir);
    end
    checks++;
    if (out_valid !== exp_ov) begin
      errors++;
      $display("FAIL sb_out_valid: got %b expected %b", out_valid, exp_ov);
    end
    checks++;
    if (out_data !== exp_od) begin
      errors++;
      $display("FAIL sb_out_data: got %h expected %h", out_data, exp_od);
    end
    acc  = in_valid && exp_ir;
    emit = exp_ov && out_ready;
    if (emit) $display("emit   data=%h", exp_od);
    if (acc)  $display("accept data=%h", in_data);
    @(posedge clk);
    if (f) begin
      sb.delete();
      last_val = NOP_VAL;
    end else begin
      if (emit) last_val = sb.pop_front();
      if (acc)  sb.push_back(in_data);
    end
    #1;
    checks++;
    if (occupancy !== 2'(sb.size())) begin
      errors++;
      $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; hold_flag = 3'b000; in_valid = 1'b1; in_data = 16'h00AA; out_ready = 1'b0;
    last_val = RESET_VAL;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== RESET_VAL) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, RESET_VAL); end
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      step();
      checks++;
      if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occupancy: got %0d expected 1", occupancy); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(i)) begin
        errors++; $display("FAIL stream_out: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, WIDTH'(i));
      end
    end
    in_valid = 1'b0;
    step();
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
    step();
    in_data = 16'h0011;
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h0010) begin
      errors++; $display("FAIL skid_full: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=0010", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 16'h0011) begin
      errors++; $display("FAIL skid_drain1: got occ=%0d rdy=%b d=%h expected occ=1 rdy=1 d=0011", occupancy, in_ready, out_data);
    end
    step();
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL skid_drain2: got occ=%0d expected 0", occupancy); end
    $display("test_backpressure done");
  endtask

  task automatic test_hold();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0022;
    step();
    in_data = 16'h0033; out_ready = 1'b1; hold_flag = 3'b010;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 16'h0022) begin
      errors++; $display("FAIL hold_outputs: got v=%b rdy=%b d=%h expected v=0 rdy=0 d=0022", out_valid, in_ready, out_data);
    end
    repeat (3) step();
    checks++;
    if (occupancy !== 2'd1 || out_data !== 16'h0022) begin
      errors++; $display("FAIL hold_keep: got occ=%0d d=%h expected occ=1 d=0022", occupancy, out_data);
    end
    hold_flag = 3'b000; in_valid = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL hold_release: got occ=%0d expected 0", occupancy); end
    $display("test_hold done");
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0040;
    step();
    in_data = 16'h0041;
    step();
    hold_flag = 3'b001; in_data = 16'h0099;
    step();
    hold_flag = 3'b000; in_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP_VAL) begin
      errors++; $display("FAIL flush_state: got occ=%0d v=%b d=%h expected occ=0 v=0 d=%h", occupancy, out_valid, out_data, NOP_VAL);
    end
    in_valid = 1'b1; in_data = 16'h0050; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 16'h0050) begin errors++; $display("FAIL flush_next: got %h expected 0050", out_data); end
    repeat (2) step();
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0060;
    step();
    in_data = 16'h0061;
    step();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== RESET_VAL || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got v=%b occ=%0d d=%h rdy=%b expected v=0 occ=0 d=%h rdy=1",
                         out_valid, occupancy, out_data, in_ready, RESET_VAL);
    end
    sb.delete();
    last_val = RESET_VAL;
    #1 rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0070; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 16'h0070) begin errors++; $display("FAIL async_first: got %h expected 0070", out_data); end
    repeat (2) step();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the plain enable/hold pipeline register.
- One pipeline stage between two core pipe stages, such as IF/ID or ID/EX.
- Adds a valid/ready handshake with a one-entry skid buffer, so upstream stalls are not needed in the same cycle as downstream backpressure.
- Keeps the 3-bit hold-flag interface (flush / hold) used by the core's stall controller and adds a configurable bubble value on flush.

Parameters:
- WIDTH, 32: payload width in bits.
- RESET_VAL, 0: value loaded into both data registers on reset.
- NOP_VAL, 0: value loaded into the output data register on flush (bubble payload).
- HOLD_W, 3: width of the hold-flag bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- hold_flag  in  HOLD_W  stage control: 3'b001 = flush, 3'b010 = hold, any other code = normal.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload available to downstream.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  WIDTH  payload to downstream.
- occupancy  out  2  number of valid entries held (0..2).

Behaviour:
- **Storage:**
  - Main register (main_d, main_v) drives out_data directly.
  - Skid register (skid_d, skid_v) holds overflow.
  - skid_v=1 implies main_v=1 at all times.
- **Reset** (rst low, asynchronous): main_v=skid_v=0; main_d=skid_d=RESET_VAL. After reset: out_valid=0, out_data=RESET_VAL, in_ready=1, occupancy=0.
- **Definitions:**
  - flush = (hold_flag==3'b001); hold = (hold_flag==3'b010). Codes are exact-compared.
  - in_ready = !skid_v & !flush & !hold. This is combinational on hold_flag; skid_v is registered.
  - out_valid = main_v & !flush & !hold.
  - acc = in_valid & in_ready; emit = out_valid & out_ready.
- **Flush** (has priority over hold and handshakes):
  - Next edge: main_v=skid_v=0, main_d=NOP_VAL, skid_d unchanged.
  - The in_data presented in the flush cycle is dropped (in_ready=0).
- **Hold:** all registers keep their values; no accept, no emit; out_data remains visible.
- **Normal update** (evaluated at the clock edge):
  - main_v=0: if acc, then main_d=in_data, main_v=1.
  - main_v=1, skid_v=0, emit & acc: main_d=in_data.
  - main_v=1, skid_v=0, emit & !acc: main_v=0; main_d retained.
  - main_v=1, skid_v=0, !emit & acc: skid_d=in_data, skid_v=1.
  - main_v=1, skid_v=1, emit: main_d=skid_d, skid_v=0. No accept is possible because in_ready=0.
  - main_v=1, no emit, no acc: no change.
- **Ordering and throughput:**
  - Strict FIFO order; no payload is duplicated or lost except by flush.
  - Latency: accept at edge N gives out_valid in cycle N+1.
  - Sustained throughput: 1 payload per cycle when out_ready=1.
- **occupancy** = main_v + skid_v, registered.
- **Mid-operation reset:** rst low clears the stage immediately, regardless of clk or hold_flag.

Test Plan:
1. **Reset:** rst=0 with in_valid=1, in_data=0xAA. Required: out_valid=0, out_data=RESET_VAL, occupancy=0. After release: in_ready=1.
2. **Streaming:** out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles. Required: out_data=1,2,3,4 one cycle later with out_valid=1 every cycle, occupancy=1 throughout.
3. **Backpressure/skid:** send 0x10 and 0x11 with out_ready=0. Required: occupancy=2, in_ready=0, out_data=0x10. Then raise out_ready. Required: 0x10, then 0x11 emitted, occupancy goes 1→0, in_ready=1 after the first emit.
4. **Hold:** stage holding 0x22 and hold_flag=3'b010 for 3 cycles, with out_ready=1 and in_valid=1. Required: out_valid=0, in_ready=0, out_data=0x22 unchanged. After hold drops: 0x22 emitted.
5. **Flush priority:** occupancy=2 and hold_flag=3'b001 with in_valid=1. Required next cycle: occupancy=0, out_valid=0, out_data=NOP_VAL, and the in_data is not seen later.
6. **Async reset mid-backpressure:** occupancy=2, pulse rst low between clock edges. Required: outputs clear without waiting for a clk edge; the next accepted payload emerges first.
